vid_stream_gen: RTL

VID_STREAM_GEN -- requirements
Module: vid_stream_gen

---
 rtl/vid_stream_gen.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vid_stream_gen.sv
// vid_stream_gen: raster video stream generator.
// Walks a frame of H_TOTAL x V_TOTAL clocks and issues pixel-memory reads for the active
// window. It then re-emits the returned pixels as a vsync/href/clken/data stream that lags
// the raster counters by two clocks.
// Optional feature: define VSG_TEST_PATTERN_EN to add an internal 8-bar colour pattern that
// is selected by pattern_sel_i. With the macro undefined, pattern_sel_i is ignored.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            frame request, sampled only while idle
//   continuous_i       1 = free-run frames, sampled at end of frame
//   pattern_sel_i      select colour bars instead of memory data (pattern build only)
//   rd_en_o, rd_addr_o pixel-memory read request (raster-order address)
//   rd_data_i          memory data, valid one clock after rd_en_o
//   vsync_o, href_o, clken_o, data_o  video stream
//   busy_o             high from the accepted start until the pipeline drains
//   frame_done_o       one-clock pulse after each completed frame
//   frame_cnt_o        completed-frame counter, wraps at 16 bits
module vid_stream_gen #(
   parameter int unsigned H_DISP  = 400,
   parameter int unsigned V_DISP  = 400,
   parameter int unsigned H_SYNC  = 5,
   parameter int unsigned H_BACK  = 5,
   parameter int unsigned H_FRONT = 5,
   parameter int unsigned V_SYNC  = 1,
   parameter int unsigned V_BACK  = 0,
   parameter int unsigned V_FRONT = 1,
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned ADDR_W  = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              continuous_i,
   input  logic              pattern_sel_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              vsync_o,
   output logic              href_o,
   output logic              clken_o,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic [15:0]       frame_cnt_o
);

   localparam int unsigned HTotal = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned VTotal = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int unsigned HAct0  = H_SYNC + H_BACK;
   localparam int unsigned VAct0  = V_SYNC + V_BACK;
   localparam int unsigned HCntW  = (HTotal > 1) ? $clog2(HTotal) : 1;
   localparam int unsigned VCntW  = (VTotal > 1) ? $clog2(VTotal) : 1;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [HCntW-1:0]  hcnt_q, hcnt_d;
   logic [VCntW-1:0]  vcnt_q, vcnt_d;
   // Raster-order pixel index; equals y*H_DISP+x while inside the active window.
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              frame_done_q, frame_done_d;

   logic [31:0]       hcnt_ext, vcnt_ext;
   logic              run, h_last, v_last, active, rd_req;

   // Stage 1 / stage 2 pipeline registers; run*_q tag each stage as belonging to a frame.
   logic              rd_en_q, act_q, vs1_q, run1_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              href_q, vs2_q, run2_q;

   always_comb begin
      hcnt_ext = 32'(hcnt_q);
      vcnt_ext = 32'(vcnt_q);
      run      = (state_q == StRun);
      h_last   = (hcnt_ext == HTotal - 1);
      v_last   = (vcnt_ext == VTotal - 1);
      active   = run && (hcnt_ext >= HAct0) && (hcnt_ext < HAct0 + H_DISP)
                     && (vcnt_ext >= VAct0) && (vcnt_ext < VAct0 + V_DISP);
   end

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      vcnt_d       = vcnt_q;
      pix_d        = pix_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         StIdle: begin
            hcnt_d = '0;
            vcnt_d = '0;
            pix_d  = '0;
            if (start_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (active) begin
               pix_d = pix_q + 1'b1;
            end
            if (h_last) begin
               hcnt_d = '0;
               if (v_last) begin
                  vcnt_d       = '0;
                  pix_d        = '0;
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  if (!continuous_i) begin
                     state_d = StIdle;
                  end
               end else begin
                  vcnt_d = vcnt_q + 1'b1;
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         pix_q        <= '0;
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         pix_q        <= pix_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef VSG_TEST_PATTERN_EN
   logic [31:0]       x_ext;
   logic [2:0]        bar_d, bar_q;
   logic              pat1_q, pat2_q;
   logic [DATA_W-1:0] col_q;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      c = 24'h000000;
      case (idx)
         3'd0: c = 24'hFFFFFF;
         3'd1: c = 24'hFFFF00;
         3'd2: c = 24'h00FFFF;
         3'd3: c = 24'h00FF00;
         3'd4: c = 24'hFF00FF;
         3'd5: c = 24'hFF0000;
         3'd6: c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   // Bar index (x*8)/H_DISP without a divider: count the bar boundaries already passed.
   always_comb begin
      x_ext = hcnt_ext - HAct0;
      bar_d = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (x_ext * 8 >= k * H_DISP) begin
            bar_d = bar_d + 3'd1;
         end
      end
      rd_req = active && !pattern_sel_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bar_q  <= '0;
         pat1_q <= 1'b0;
         pat2_q <= 1'b0;
         col_q  <= '0;
      end else begin
         bar_q  <= bar_d;
         pat1_q <= pattern_sel_i;
         pat2_q <= pat1_q;
         col_q  <= DATA_W'(bar_colour(bar_q));
      end
   end

   assign data_o = href_q ? (pat2_q ? col_q : rd_data_i) : '0;
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = pattern_sel_i;
   assign rd_req = active;
   assign data_o = href_q ? rd_data_i : '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         act_q     <= 1'b0;
         vs1_q     <= 1'b0;
         run1_q    <= 1'b0;
         href_q    <= 1'b0;
         vs2_q     <= 1'b0;
         run2_q    <= 1'b0;
      end else begin
         rd_en_q   <= rd_req;
         rd_addr_q <= rd_req ? pix_q : '0;
         act_q     <= active;
         vs1_q     <= run && (vcnt_ext >= V_SYNC);
         run1_q    <= run;
         href_q    <= act_q;
         // Extra vsync stage keeps it aligned with href.
         vs2_q     <= vs1_q;
         run2_q    <= run1_q;
      end
   end

   assign rd_en_o      = rd_en_q;
   assign rd_addr_o    = rd_addr_q;
   assign href_o       = href_q;
   assign clken_o      = href_q;
   assign vsync_o      = vs2_q;
   assign busy_o       = run | run1_q | run2_q;
   assign frame_done_o = frame_done_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule
